// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data bits sent LSB first,
// optional even/odd parity and one or two stop bits, each held CLKS_PER_BIT cycles.
module uart_tx_cfg #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clkIN,
  input  logic                 resetIN,
  input  logic [DATA_BITS-1:0] dataIN,
  input  logic                 sendIN,
  output logic                 txOUT,
  output logic                 nBusyOUT,
  output logic                 doneOUT
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("uart_tx_cfg: CLKS_PER_BIT must be 2..65535");
  end

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] D_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    if (PARITY == 2) begin
      return ~(^d);
    end else begin
      return ^d;
    end
  endfunction

  state_t                 state_q;
  logic                   tx_q;
  logic                   nbusy_q;
  logic                   done_q;
  logic                   armed_q;
  logic [TW-1:0]          timer_q;
  logic [BW-1:0]          bitcnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   parity_d;
  logic                   bit_end_s;

  assign parity_d  = calc_parity(dataIN);
  assign bit_end_s = (timer_q == T_LAST);

  // Frame sequencer: the bit timer runs in every non-idle state and wraps at each bit boundary.
  always_ff @(posedge clkIN or posedge resetIN) begin
    if (resetIN) begin
      state_q  <= ST_IDLE;
      tx_q     <= 1'b1;
      nbusy_q  <= 1'b1;
      done_q   <= 1'b0;
      armed_q  <= 1'b1;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!sendIN) begin
        armed_q <= 1'b1;
      end
      if (state_q != ST_IDLE) begin
        timer_q <= bit_end_s ? '0 : timer_q + TW'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (sendIN && armed_q) begin
            shift_q  <= dataIN;
            par_q    <= parity_d;
            tx_q     <= 1'b0;
            nbusy_q  <= 1'b0;
            timer_q  <= '0;
            armed_q  <= 1'b0;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            tx_q     <= shift_q[0];
            shift_q  <= {1'b0, shift_q[DATA_BITS-1:1]};
            bitcnt_q <= '0;
            state_q  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            if (bitcnt_q == D_LAST) begin
              bitcnt_q <= '0;
              if (PARITY != 0) begin
                tx_q    <= par_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              bitcnt_q <= bitcnt_q + BW'(1);
              tx_q     <= shift_q[0];
              shift_q  <= {1'b0, shift_q[DATA_BITS-1:1]};
            end
          end
        end
        ST_PARITY: begin
          if (bit_end_s) begin
            tx_q     <= 1'b1;
            bitcnt_q <= '0;
            state_q  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            if (bitcnt_q == S_LAST) begin
              bitcnt_q <= '0;
              nbusy_q  <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= ST_IDLE;
            end else begin
              bitcnt_q <= bitcnt_q + BW'(1);
            end
          end
        end
        default: begin
          tx_q     <= 1'b1;
          nbusy_q  <= 1'b1;
          timer_q  <= '0;
          bitcnt_q <= '0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign txOUT    = tx_q;
  assign nBusyOUT = nbusy_q;
  assign doneOUT  = done_q;

endmodule
